// File: rtl/keypad_matrix_decoder.sv
// Scans a 4x4 keypad, debounces each key, and queues press events for a valid/ready consumer.
// Press-to-valid: (DEBOUNCE_SCANS-1) frames + slot + 1; a full queue with no pop drops the event and pulses key_overflow.
module keypad_matrix_decoder #(
  parameter int SCAN_DIV       = 2500,
  parameter int SETTLE_CYC     = 8,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  keyboard_col,
  input  logic [3:0]  keyboard_row,
  output logic [3:0]  key_code,
  output logic        key_valid,
  input  logic        key_ready,
  output logic        key_overflow,
  output logic [15:0] key_down
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [DIV_W-1:0] r_div_cnt;
  logic [1:0]       r_col;
  logic [3:0]       r_col_drv;
  logic [3:0]       r_row_meta;
  logic [3:0]       r_row_sync;
  logic [1:0]       r_cnt [16];
  logic [15:0]      r_key_down;
  logic [3:0]       r_pend;
  logic [1:0]       r_pend_col;
  logic [3:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;

  logic             w_wrap;
  logic             w_sample;
  logic [3:0]       w_idx [4];
  logic [3:0]       w_diff;
  logic [3:0]       w_fire;
  logic [3:0]       w_new_press;
  logic [1:0]       w_push_row;
  logic [3:0]       w_push_clr;
  logic             w_push;
  logic [3:0]       w_push_code;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push_ok;

  assign w_wrap   = (r_div_cnt == DIV_W'(SCAN_DIV - 1));
  assign w_sample = (r_div_cnt == DIV_W'(SETTLE_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_col     <= 2'd0;
      r_col_drv <= 4'b1110;
    end else if (w_wrap) begin
      r_div_cnt <= '0;
      r_col     <= r_col + 2'd1;
      r_col_drv <= ~(4'b0001 << (r_col + 2'd1));
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_meta <= 4'hF;
      r_row_sync <= 4'hF;
    end else begin
      r_row_meta <= keyboard_row;
      r_row_sync <= r_row_meta;
    end
  end

  // Key index is {row, col}; only the four keys of the driven column are evaluated.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      w_idx[r]       = {2'(r), r_col};
      w_diff[r]      = (~r_row_sync[r]) ^ r_key_down[w_idx[r]];
      w_fire[r]      = w_sample && w_diff[r] &&
                       (({1'b0, r_cnt[w_idx[r]]} + 3'd1) == 3'(DEBOUNCE_SCANS));
      w_new_press[r] = w_fire[r] && !r_row_sync[r];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) r_cnt[k] <= 2'd0;
      r_key_down <= 16'h0;
    end else if (w_sample) begin
      for (int r = 0; r < 4; r++) begin
        if (w_fire[r]) begin
          r_key_down[w_idx[r]] <= ~r_key_down[w_idx[r]];
          r_cnt[w_idx[r]]      <= 2'd0;
        end else if (w_diff[r]) begin
          r_cnt[w_idx[r]] <= r_cnt[w_idx[r]] + 2'd1;
        end else begin
          r_cnt[w_idx[r]] <= 2'd0;
        end
      end
    end
  end

  // Lowest pending row goes first, so simultaneous presses enter the queue in row order.
  always_comb begin
    w_push_row = 2'd0;
    w_push_clr = 4'b0000;
    for (int r = 3; r >= 0; r--) begin
      if (r_pend[r]) begin
        w_push_row = 2'(r);
        w_push_clr = 4'b0001 << r;
      end
    end
  end

  assign w_push      = |r_pend;
  assign w_push_code = {w_push_row, r_pend_col};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend     <= 4'b0000;
      r_pend_col <= 2'd0;
    end else if (w_sample) begin
      r_pend     <= w_new_press;
      r_pend_col <= r_col;
    end else begin
      r_pend <= r_pend & ~w_push_clr;
    end
  end

  assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_pop     = !w_empty && key_ready;
  assign w_push_ok = w_push && (!w_full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 4'h0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_push && w_full && !w_pop;
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= w_push_code;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign keyboard_col = r_col_drv;
  assign key_valid    = !w_empty;
  assign key_code     = r_mem[r_rd_ptr];
  assign key_overflow = r_overflow;
  assign key_down     = r_key_down;

endmodule

// File: tb/tb_keypad_matrix_decoder.sv
// Directed bench for keypad_matrix_decoder: ideal keypad model, handshake monitor, vector table plus timed sequences.
module tb_keypad_matrix_decoder;

  localparam int FRAME = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  keyboard_col;
  logic [3:0]  keyboard_row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready = 1'b0;
  logic        key_overflow;
  logic [15:0] key_down;
  logic [15:0] keys = 16'h0;

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] obs [$];
  int ovf_cnt = 0;

  keypad_matrix_decoder #(
    .SCAN_DIV(16), .SETTLE_CYC(4), .DEBOUNCE_SCANS(3), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .keyboard_col(keyboard_col), .keyboard_row(keyboard_row),
    .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
    .key_overflow(key_overflow), .key_down(key_down)
  );

  always #5 clk = ~clk;

  // A closed key pulls its row low while its column is driven low.
  always_comb begin
    keyboard_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !keyboard_col[c]) keyboard_row[r] = 1'b0;
  end

  // Inputs change 1 time unit after posedge, so the negedge sees what the next posedge uses.
  always @(negedge clk) begin
    if (!rst) begin
      if (key_valid && key_ready) obs.push_back(key_code);
      if (key_overflow) ovf_cnt = ovf_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] keys;
    int          frames;
    logic        ready;
    logic [15:0] exp_down;
    int          exp_pops;
    logic [15:0] exp_codes;
    int          exp_ovf;
  } vec_t;

  vec_t vecs [15];

  task automatic apply_vec(input int i);
    int base;
    int ovf_base;
    logic [15:0] codes;
    base     = obs.size();
    ovf_base = ovf_cnt;
    keys      = vecs[i].keys;
    key_ready = vecs[i].ready;
    repeat (vecs[i].frames * FRAME) tick();
    codes = vecs[i].exp_codes;
    chk($sformatf("v%0d key_down", i), key_down, vecs[i].exp_down);
    chk($sformatf("v%0d pop count", i), obs.size() - base, vecs[i].exp_pops);
    chk($sformatf("v%0d overflow count", i), ovf_cnt - ovf_base, vecs[i].exp_ovf);
    for (int j = 0; j < vecs[i].exp_pops; j++)
      if (base + j < obs.size())
        chk($sformatf("v%0d code%0d", i, j), obs[base+j], codes[j*4 +: 4]);
  endtask

  task automatic drain_test4();
    logic [3:0] exp_seq [4];
    exp_seq = '{4'h1, 4'h2, 4'h3, 4'h4};
    chk("t4 full valid", key_valid, 1'b1);
    key_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("t4 drain valid%0d", j), key_valid, 1'b1);
      chk($sformatf("t4 drain code%0d", j), key_code, exp_seq[j]);
      tick();
    end
    chk("t4 empty after drain", key_valid, 1'b0);
  endtask

  task automatic test5();
    logic [3:0] prev;
    logic [3:0] exp_seq [4];
    bit found;
    int base;
    int ovf_base;
    exp_seq = '{4'h6, 4'hA, 4'hE, 4'h5};
    chk("t5 full valid", key_valid, 1'b1);
    found = 1'b0;
    prev  = keyboard_col;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (keyboard_col == 4'b1101 && prev != 4'b1101) found = 1'b1;
      prev = keyboard_col;
    end
    chk("t5 col1 sync", found, 1'b1);
    keys = keys | 16'h0020;
    repeat (132) tick();
    chk("t5 head before pop", key_code, 4'h2);
    base     = obs.size();
    ovf_base = ovf_cnt;
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    repeat (4) tick();
    chk("t5 no overflow", ovf_cnt - ovf_base, 0);
    chk("t5 one pop", obs.size() - base, 1);
    chk("t5 still full", key_valid, 1'b1);
    chk("t5 key5 down", key_down[5], 1'b1);
    key_ready = 1'b1;
    repeat (6) tick();
    chk("t5 total pops", obs.size() - base, 5);
    if (obs.size() >= base + 5)
      for (int j = 0; j < 4; j++)
        chk($sformatf("t5 order%0d", j), obs[base+1+j], exp_seq[j]);
    chk("t5 empty", key_valid, 1'b0);
  endtask

  task automatic test_reset();
    int base;
    logic [3:0] exp_seq [3];
    exp_seq = '{4'h5, 4'h2, 4'hE};
    keys = keys | 16'h0020;
    repeat (80) tick();
    chk("rst pre key_down", key_down, 16'h4004);
    chk("rst pre valid", key_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst col", keyboard_col, 4'b1110);
    chk("rst valid", key_valid, 1'b0);
    chk("rst code", key_code, 4'h0);
    chk("rst overflow", key_overflow, 1'b0);
    chk("rst key_down", key_down, 16'h0);
    repeat (3) tick();
    rst = 1'b0;
    key_ready = 1'b0;
    repeat (148) tick();
    chk("rerep not yet valid", key_valid, 1'b0);
    tick();
    chk("rerep valid", key_valid, 1'b1);
    chk("rerep code", key_code, 4'h5);
    base = obs.size();
    key_ready = 1'b1;
    repeat (2 * FRAME) tick();
    chk("rerep pops", obs.size() - base, 3);
    if (obs.size() >= base + 3)
      for (int j = 0; j < 3; j++)
        chk($sformatf("rerep order%0d", j), obs[base+j], exp_seq[j]);
    chk("rerep key_down", key_down, 16'h4024);
  endtask

  initial begin
    logic [3:0] exp_col [5];
    exp_col = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

    //        keys      frm rdy exp_down  pops codes     ovf
    vecs[0]  = '{16'h0200, 4, 1, 16'h0200, 1, 16'h0009, 0};
    vecs[1]  = '{16'h0000, 4, 1, 16'h0000, 0, 16'h0000, 0};
    vecs[2]  = '{16'h0008, 2, 1, 16'h0000, 0, 16'h0000, 0};
    vecs[3]  = '{16'h0000, 4, 1, 16'h0000, 0, 16'h0000, 0};
    vecs[4]  = '{16'h0002, 4, 0, 16'h0002, 0, 16'h0000, 0};
    vecs[5]  = '{16'h0006, 4, 0, 16'h0006, 0, 16'h0000, 0};
    vecs[6]  = '{16'h000E, 4, 0, 16'h000E, 0, 16'h0000, 0};
    vecs[7]  = '{16'h001E, 4, 0, 16'h001E, 0, 16'h0000, 0};
    vecs[8]  = '{16'h003E, 4, 0, 16'h003E, 0, 16'h0000, 1};
    vecs[9]  = '{16'h0000, 4, 1, 16'h0000, 0, 16'h0000, 0};
    vecs[10] = '{16'h4444, 4, 0, 16'h4444, 0, 16'h0000, 0};
    vecs[11] = '{16'h0000, 4, 1, 16'h0000, 0, 16'h0000, 0};
    vecs[12] = '{16'h4004, 4, 1, 16'h4004, 2, 16'h00E2, 0};
    vecs[13] = '{16'h0000, 4, 1, 16'h0000, 0, 16'h0000, 0};
    vecs[14] = '{16'h4004, 4, 0, 16'h4004, 0, 16'h0000, 0};

    repeat (3) tick();
    chk("reset col", keyboard_col, 4'b1110);
    chk("reset valid", key_valid, 1'b0);
    chk("reset code", key_code, 4'h0);
    chk("reset overflow", key_overflow, 1'b0);
    chk("reset key_down", key_down, 16'h0);
    rst = 1'b0;
    for (int f = 0; f < 5; f++) begin
      repeat (f == 0 ? 8 : 16) tick();
      chk($sformatf("scan col step%0d", f), keyboard_col, exp_col[f]);
    end
    chk("idle valid", key_valid, 1'b0);
    chk("idle key_down", key_down, 16'h0);

    for (int i = 0; i < 15; i++) begin
      apply_vec(i);
      if (i == 8)  drain_test4();
      if (i == 10) test5();
    end
    test_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
